mem_port_arbiter: RTL and testbench

Sequencing controller that shares a single unified memory port between the instruction-fetch stage and the memory stage of the 5-stage pipeline. It arbitrates between the two requesters and runs each access as a held-request/acknowledge transaction with the memory. It returns read data to the winning requester and generates the stall signals that freeze the fetch and memory stages while their access is pending. Data accesses have priority, and a bounded streak counter prevents fetch starvation.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and the memory stage.
// Data accesses win arbitration, but a bounded streak of data grants keeps fetch from starving.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              owner
);

  localparam int unsigned         STREAK_W   = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, RESP} stateT;

  stateT               state;
  logic [STREAK_W-1:0] streak;
  logic                dmWins;

  // Data wins unless fetch is waiting and has already been passed over too often.
  assign dmWins    = dm_req && !(if_req && (streak == STREAK_MAX));
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dm_req & ~dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      owner     <= 1'b0;
      streak    <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dmWins) begin
            state     <= DM_XFER;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            owner     <= 1'b1;
            if (!if_req) begin
              streak <= '0;
            end else if (streak < STREAK_MAX) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (if_req) begin
            state    <= IF_XFER;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            owner    <= 1'b0;
            streak   <= '0;
          end
        end
        IF_XFER: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        DM_XFER: begin
          // Stores capture too; the returned value is simply unused.
          if (mem_ack) begin
            dm_rdata <= mem_rdata;
            dm_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester and memory models, a scoreboard of expected
// read data, a table of single transactions and hand sequences for arbitration corners.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;
  logic              owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .owner(owner)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
    logic              chk;
  } reqT;

  typedef struct {
    logic              isData;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                waitSt;
    logic [DATA_W-1:0] expRdata;
    logic              chkRdata;
    int                expLat;
  } vecT;

  reqT  ifExpQ[$];
  reqT  dmExpQ[$];
  reqT  ifNextQ[$];
  reqT  dmNextQ[$];
  logic grantLog[$];

  int   passCnt    = 0;
  int   totalCnt   = 0;
  int   memWait    = 0;
  int   waitCnt    = 0;
  bit   memAuto    = 1'b1;
  logic forceAck   = 1'b0;
  logic prevMemReq = 1'b0;

  function automatic logic [DATA_W-1:0] memFn(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic reqT mkReq(input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] e,
                                input logic c);
    reqT r;
    r.we = we; r.addr = a; r.wdata = wd; r.exp = e; r.chk = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  task automatic issueIf(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    if_req  = 1'b1;
    if_addr = a;
    ifExpQ.push_back(mkReq(1'b0, a, '0, e, 1'b1));
  endtask

  task automatic issueDm(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] e,
                         input logic c);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dmExpQ.push_back(mkReq(we, a, wd, e, c));
  endtask

  // One clock: observe, score completions, advance requesters, then drive the memory.
  task automatic step();
    reqT r;
    @(posedge clk);
    #1;
    if (mem_req && !prevMemReq) grantLog.push_back(owner);
    prevMemReq = mem_req;
    if (if_done) begin
      chk("if_done_expected", 32'(ifExpQ.size() != 0), 32'd1);
      if (ifExpQ.size() != 0) begin
        r = ifExpQ.pop_front();
        if (r.chk) chk("if_rdata", if_rdata, r.exp);
      end
      if (ifNextQ.size() != 0) begin
        r = ifNextQ.pop_front();
        if_addr = r.addr;
        ifExpQ.push_back(r);
      end else begin
        if_req = 1'b0;
      end
    end
    if (dm_done) begin
      chk("dm_done_expected", 32'(dmExpQ.size() != 0), 32'd1);
      if (dmExpQ.size() != 0) begin
        r = dmExpQ.pop_front();
        if (r.chk) chk("dm_rdata", dm_rdata, r.exp);
      end
      if (dmNextQ.size() != 0) begin
        r = dmNextQ.pop_front();
        dm_we    = r.we;
        dm_addr  = r.addr;
        dm_wdata = r.wdata;
        dmExpQ.push_back(r);
      end else begin
        dm_req = 1'b0;
      end
    end
    if (memAuto && mem_req) begin
      if (waitCnt >= memWait) begin
        mem_ack   = 1'b1;
        mem_rdata = memFn(mem_addr);
        waitCnt   = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        waitCnt++;
      end
    end else begin
      mem_ack   = forceAck;
      mem_rdata = $urandom;
      waitCnt   = 0;
    end
  endtask

  initial begin
    vecT  vecs[5];
    logic expPat[10];
    int   k;
    int   dmK;
    int   ifK;
    bit   seen;
    logic stallNow;
    logic doneNow;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h0050_0093, 1'b1, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3, 32'h0,         1'b0, 5};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,         1, 32'hEDCB_1234, 1'b1, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         2, 32'hFFBF_0040, 1'b1, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         0, 32'hFFFB_0004, 1'b1, 2};
    expPat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_dm_rdata",  dm_rdata,       32'd0);
    chk("rst_if_done",   32'(if_done),   32'd0);
    chk("rst_dm_done",   32'(dm_done),   32'd0);
    chk("rst_owner",     32'(owner),     32'd0);
    rst = 1'b0;
    step();

    // Single transactions from the table, issued from IDLE.
    for (int v = 0; v < 5; v++) begin
      memWait = vecs[v].waitSt;
      if (vecs[v].isData)
        issueDm(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].expRdata, vecs[v].chkRdata);
      else
        issueIf(vecs[v].addr, vecs[v].expRdata);
      #1;
      stallNow = vecs[v].isData ? stall_mem : stall_if;
      chk("stall_c0", 32'(stallNow), 32'd1);
      k = 0;
      doneNow = 1'b0;
      while (!doneNow && k < 40) begin
        step();
        k++;
        doneNow  = vecs[v].isData ? dm_done : if_done;
        stallNow = vecs[v].isData ? stall_mem : stall_if;
        if (!doneNow) begin
          chk("xfer_mem_req", 32'(mem_req), 32'(k <= 1 + vecs[v].waitSt));
          chk("xfer_stall", 32'(stallNow), 32'd1);
          if (mem_req) begin
            chk("xfer_mem_we",   32'(mem_we),   32'(vecs[v].isData & vecs[v].we));
            chk("xfer_mem_addr", mem_addr,      vecs[v].addr);
            chk("xfer_owner",    32'(owner),    32'(vecs[v].isData));
            if (vecs[v].isData && vecs[v].we) chk("xfer_mem_wdata", mem_wdata, vecs[v].wdata);
          end
        end
      end
      chk("latency",      32'(k),        32'(vecs[v].expLat));
      chk("stall_done",   32'(stallNow), 32'd0);
      chk("mem_req_done", 32'(mem_req),  32'd0);
      step();
      doneNow = vecs[v].isData ? dm_done : if_done;
      chk("done_one_cycle", 32'(doneNow), 32'd0);
    end

    // Simultaneous requests: data first, fetch three cycles later.
    memWait = 0;
    issueIf(32'h0000_0040, 32'hFFBF_0040);
    issueDm(1'b0, 32'h0000_1234, '0, 32'hEDCB_1234, 1'b1);
    k = 0; dmK = -1; ifK = -1;
    while (ifK < 0 && k < 20) begin
      step();
      k++;
      if (k == 1) chk("sim_owner_first", 32'(owner), 32'd1);
      if (k == 4) chk("sim_owner_second", 32'(owner), 32'd0);
      if (dm_done) dmK = k;
      if (if_done) ifK = k;
      else chk("sim_stall_if", 32'(stall_if), 32'd1);
    end
    chk("sim_dm_done_cycle", 32'(dmK), 32'd2);
    chk("sim_if_done_cycle", 32'(ifK), 32'd5);
    step();

    // Starvation bound: both requesters stay busy; fetch gets in after every 4 data grants.
    grantLog.delete();
    issueIf(32'h0000_0100, 32'h0050_0093);
    ifNextQ.push_back(mkReq(1'b0, 32'h0000_0104, '0, 32'hFEFB_0104, 1'b1));
    issueDm(1'b0, 32'h0000_0010, '0, 32'hFFEF_0010, 1'b1);
    for (int i = 1; i < 8; i++)
      dmNextQ.push_back(mkReq(1'b0, 32'(32'h10 + 4 * i), '0, memFn(32'(32'h10 + 4 * i)), 1'b1));
    k = 0;
    while ((if_req || dm_req) && k < 300) begin
      step();
      k++;
    end
    chk("starve_finished", 32'(if_req | dm_req), 32'd0);
    chk("starve_grants", 32'(grantLog.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < grantLog.size()) chk($sformatf("starve_owner_%0d", i), 32'(grantLog[i]), 32'(expPat[i]));
    end
    step();

    // Reset in the middle of a store, then a late ack.
    memAuto = 1'b0;
    forceAck = 1'b0;
    issueDm(1'b1, 32'h0000_3000, 32'h1234_5678, '0, 1'b0);
    step();
    step();
    chk("rst_mid_pre_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    dm_req = 1'b0;
    dmExpQ.delete();
    step();
    chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
    rst = 1'b0;
    forceAck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dm_done || if_done || mem_req) seen = 1'b1;
    end
    chk("rst_mid_quiet",     32'(seen),   32'd0);
    chk("rst_mid_owner",     32'(owner),  32'd0);
    chk("rst_mid_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mid_mem_addr",  mem_addr,    32'd0);
    chk("rst_mid_mem_wdata", mem_wdata,   32'd0);
    chk("rst_mid_if_rdata",  if_rdata,    32'd0);
    chk("rst_mid_dm_rdata",  dm_rdata,    32'd0);
    forceAck = 1'b0;
    memAuto = 1'b1;
    step();

    // After reset the arbiter must be idle: a fresh fetch takes the minimum latency.
    memWait = 0;
    issueIf(32'h0000_0100, 32'h0050_0093);
    k = 0;
    doneNow = 1'b0;
    while (!doneNow && k < 20) begin
      step();
      k++;
      doneNow = if_done;
    end
    chk("post_rst_latency", 32'(k), 32'd2);
    step();

    // Spurious ack with nobody requesting.
    forceAck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if_done || dm_done || mem_req) seen = 1'b1;
    end
    forceAck = 1'b0;
    step();
    chk("spur_quiet",    32'(seen), 32'd0);
    chk("spur_if_rdata", if_rdata,  32'h0050_0093);
    chk("spur_dm_rdata", dm_rdata,  32'd0);

    chk("if_sb_empty", 32'(ifExpQ.size()), 32'd0);
    chk("dm_sb_empty", 32'(dmExpQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
